serial_tx_fifo: RTL and testbench

Parametrised UART transmitter with a built-in word FIFO, baud-tick generation from a single system clock, configurable frame format (data bits, optional parity, 1 or 2 stop bits) and back-to-back framing. It sits between the host-side byte producer and the board TX pin. It replaces single-byte transmitters that derive a separate baud clock and accept only one word at a time.

---
 rtl/serial_pkg.sv | 24 ++
 rtl/serial_tx_word_fifo.sv | 71 +++++++
 rtl/serial_tx_fifo.sv | 193 +++++++++++++++++++
 tb/tb_serial_tx_fifo.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial transmitter slice.
//  - tx_state_e : transmitter FSM states (IDLE, START, DATA, PARITY, STOP)
//  - PARITY_*   : values accepted by the PARITY_MODE parameter
//  - parity_bit : parity of a data word (up to 9 bits) for a given mode
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Callers zero-extend narrower words; extra zeros leave the XOR unchanged.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    parity_bit = (mode == PARITY_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/serial_tx_word_fifo.sv
// Synchronous word FIFO with registered occupancy count.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   push, wdata   write strobe and word; ignored when full
//   pop, rdata    read strobe; rdata shows the head word (valid when !empty)
//   full, empty   decoded from the registered count
//   count         words held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module serial_tx_word_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_tx_fifo.sv
// UART transmitter fed by a word FIFO, single clock, baud timing by counter.
// Ports:
//   CLK, RESET_N       system clock, async active-low reset
//   IN_DATA, IN_SEND   word (LSB first on the line) and write strobe;
//                      accepted when IN_SEND && OUT_STATUS_READY
//   OUT_SERIAL_TX      registered serial line, idles high
//   OUT_STATUS_READY   registered FIFO-not-full (low during/after reset
//                      until the first clock edge)
//   OUT_BUSY           frame in flight or FIFO non-empty
//   OUT_FIFO_COUNT     words waiting in the FIFO
//   OUT_OVERFLOW       sticky: a write was attempted while not ready
// Build option: define SERIAL_TX_PARITY_EN to compile in the parity bit;
// PARITY_MODE is only honoured in that build.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic [DATA_BITS-1:0]          IN_DATA,
  input  logic                          IN_SEND,
  output logic                          OUT_SERIAL_TX,
  output logic                          OUT_STATUS_READY,
  output logic                          OUT_BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   OUT_FIFO_COUNT,
  output logic                          OUT_OVERFLOW
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  tx_state_e             state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [IW-1:0]         bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  ovf_q, ovf_d;

  logic                  accept, pop;
  logic                  baud_end, stop_last;
  logic                  fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rdata;
  logic [CW-1:0]         fifo_count, cnt_nxt;

`ifdef SERIAL_TX_PARITY_EN
  localparam bit PAR_ON = (PARITY_MODE != PARITY_NONE);
  logic par_q, par_d;
`endif

  assign accept    = IN_SEND & ready_q & ~fifo_full;
  assign baud_end  = (baud_q == BAUD_LAST);
  assign stop_last = (STOP_BITS == 1) || stop_q;

  serial_tx_word_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (accept),
    .wdata (IN_DATA),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      IDLE:  pop = ~fifo_empty;
      START: if (baud_end) state_d = DATA;
      DATA: begin
        if (baud_end) begin
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = STOP;
`ifdef SERIAL_TX_PARITY_EN
            if (PAR_ON) state_d = PARITY;
`endif
          end else begin
            bit_d   = bit_q + IW'(1);
            shift_d = shift_q >> 1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (baud_end) state_d = STOP;
`endif
      STOP: begin
        if (baud_end) begin
          if (stop_last) begin
            // Chaining straight into START keeps frames gap-free.
            state_d = IDLE;
            pop     = ~fifo_empty;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d = START;
      shift_d = fifo_rdata;
      bit_d   = '0;
      stop_d  = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_d   = parity_bit(9'(fifo_rdata), PARITY_MODE);
`endif
    end

    // Counter restarts on every pop so each start bit gets a full period.
    if (pop || state_q == IDLE) baud_d = '0;
    else if (baud_end)          baud_d = '0;
    else                        baud_d = baud_q + BW'(1);

    // Line value follows the next state so it changes on the same edge.
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_comb begin
    cnt_nxt = fifo_count;
    if (accept && !pop)      cnt_nxt = fifo_count + CW'(1);
    else if (!accept && pop) cnt_nxt = fifo_count - CW'(1);
    ready_d = (cnt_nxt != CNT_FULL);
    ovf_d   = ovf_q | (IN_SEND & ~ready_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign OUT_SERIAL_TX    = tx_q;
  assign OUT_STATUS_READY = ready_q;
  assign OUT_BUSY         = (state_q != IDLE) | ~fifo_empty;
  assign OUT_FIFO_COUNT   = fifo_count;
  assign OUT_OVERFLOW     = ovf_q;

endmodule

// File: tb/tb_serial_tx_fifo.sv
// Bench for serial_tx_fifo: a queue/waveform model tracks accepted words and
// the expected line level per cycle; a compare process checks every output
// on each falling edge. Directed sequences pin the model with literal values.
module tb_serial_tx_fifo;

  localparam int C   = 4;
  localparam int D   = 8;
  localparam int PM  = 2;
  localparam int S   = 2;
  localparam int DEP = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int P         = 1;
  localparam int FRAME_LIT = 48;
`else
  localparam int P         = 0;
  localparam int FRAME_LIT = 44;
`endif
  localparam int CW = $clog2(DEP) + 1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic [D-1:0]  IN_DATA = '0;
  logic          IN_SEND = 1'b0;
  logic          tx, rdy, busy, ovf;
  logic [CW-1:0] cnt;

  int total = 0;
  int bad   = 0;

  // Model state
  logic [D-1:0] m_q[$];
  bit           wave[$];
  bit           m_rdy = 1'b0, m_ovf = 1'b0, m_tx = 1'b1, m_busy = 1'b0;
  bit           m_acc;
  logic [D-1:0] m_w;

  serial_tx_fifo #(
    .CLKS_PER_BIT (C),
    .DATA_BITS    (D),
    .PARITY_MODE  (PM),
    .STOP_BITS    (S),
    .FIFO_DEPTH   (DEP)
  ) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .IN_DATA          (IN_DATA),
    .IN_SEND          (IN_SEND),
    .OUT_SERIAL_TX    (tx),
    .OUT_STATUS_READY (rdy),
    .OUT_BUSY         (busy),
    .OUT_FIFO_COUNT   (cnt),
    .OUT_OVERFLOW     (ovf)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is just a list of line levels, one per cycle.
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      m_q.delete();
      wave.delete();
      m_rdy  = 1'b0;
      m_ovf  = 1'b0;
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      m_acc = IN_SEND && m_rdy;
      if (IN_SEND && !m_rdy) m_ovf = 1'b1;
      if (wave.size() == 0 && m_q.size() > 0) begin
        m_w = m_q.pop_front();
        for (int i = 0; i < C; i++) wave.push_back(1'b0);
        for (int b = 0; b < D; b++)
          for (int i = 0; i < C; i++) wave.push_back(m_w[b]);
        if (P == 1)
          for (int i = 0; i < C; i++) wave.push_back((PM == 1) ? ~(^m_w) : (^m_w));
        for (int i = 0; i < S * C; i++) wave.push_back(1'b1);
      end
      if (wave.size() > 0) begin
        m_tx   = wave.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
      if (m_acc) m_q.push_back(IN_DATA);
      m_busy = m_busy || (m_q.size() > 0);
      m_rdy  = (m_q.size() < DEP);
    end
  end

  always @(negedge CLK) begin
    chk("tx",    tx,   m_tx);
    chk("ready", rdy,  m_rdy);
    chk("busy",  busy, m_busy);
    chk("count", cnt,  m_q.size());
    chk("ovf",   ovf,  m_ovf);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int probs[4] = '{2, 15, 60, 95};

  initial begin
    // Reset state
    step(3);
    chk("rst_tx", tx, 1);
    chk("rst_ready", rdy, 0);
    chk("rst_count", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    #2 RESET_N = 1'b1;
    step(1);
    chk("ready_after_rst", rdy, 1);

    // Basic frame: 0xA5
    IN_SEND = 1'b1; IN_DATA = 8'hA5;
    step(1);
    IN_SEND = 1'b0; IN_DATA = 8'h00;
    chk("a5_count_k", cnt, 1);
    chk("a5_tx_k", tx, 1);
    step(1);
    chk("a5_start", tx, 0);
    chk("a5_busy", busy, 1);
    chk("a5_count_pop", cnt, 0);
    step(4);
    chk("a5_bit0", tx, 1);
    step(4);
    chk("a5_bit1", tx, 0);
    step(FRAME_LIT - 9);
    chk("a5_last_stop_busy", busy, 1);
    chk("a5_last_stop_tx", tx, 1);
    step(1);
    chk("a5_done_busy", busy, 0);

`ifdef SERIAL_TX_PARITY_EN
    // Even parity of 0x07 is 1
    IN_SEND = 1'b1; IN_DATA = 8'h07;
    step(1);
    IN_SEND = 1'b0;
    step(1 + C * (1 + D));
    chk("par_07_even", tx, 1);
    step(FRAME_LIT);
`endif

    // FIFO fill: six consecutive writes into depth 4
    for (int i = 0; i < 6; i++) begin
      IN_SEND = 1'b1; IN_DATA = D'(8'h10 + i);
      step(1);
    end
    IN_SEND = 1'b0;
    chk("fill_count", cnt, 4);
    chk("fill_ready", rdy, 0);
    chk("fill_ovf", ovf, 1);
    step(5 * FRAME_LIT + 10);
    chk("fill_drained", busy, 0);

    // Reset during DATA phase
    IN_SEND = 1'b1; IN_DATA = 8'h3C;
    step(1);
    IN_SEND = 1'b0;
    step(10);
    #2 RESET_N = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_count", cnt, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", ovf, 0);
    step(2);
    #2 RESET_N = 1'b1;
    step(1);
    chk("mid_rst_ready", rdy, 1);
    IN_SEND = 1'b1; IN_DATA = 8'h3C;
    step(1);
    IN_SEND = 1'b0;
    step(FRAME_LIT + 5);
    chk("post_rst_idle", busy, 0);

    // Randomized traffic at several write densities
    foreach (probs[p]) begin
      repeat (1200) begin
        @(negedge CLK);
        IN_SEND = ($urandom_range(0, 99) < probs[p]);
        IN_DATA = D'($urandom);
      end
    end
    @(negedge CLK);
    IN_SEND = 1'b0;
    step((DEP + 1) * FRAME_LIT + 20);
    chk("final_idle", busy, 0);
    chk("final_count", cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
